weight_buffer_loader: RTL and testbench



---
 rtl/weight_buffer_loader.sv | 135 +++++++++++++
 tb/tb_weight_buffer_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer_loader.sv
// weight_buffer_loader
//   Write-side sequencer for the weight buffer bank array. It takes one load
//   command (base row, row count) and turns the DDR beat stream into bank
//   writes. Each beat fills one group of GROUP_BANKS banks at the current
//   row, and GROUPS beats complete a row. done pulses together with the
//   final write.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   cmd_*            load command handshake: base row address and row count
//   ddr_*            DDR read beat stream (valid/ready)
//   data_wr          registered beat data, fanned to every group by the buffer
//   wr_addr          registered write row, shared by all banks
//   wr_en            registered per-bank write enable (one group per beat)
//   busy, done       command in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | accepting beats and issuing bank writes
// DONE  | final write on the port, done pulse, back to IDLE next cycle
module weight_buffer_loader #(
  parameter int X_PE         = 16,
  parameter int X_MESH       = 16,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 64,
  parameter int DDR_DATA_LEN = 256,
  parameter int BUFFER_NUM   = 8 * X_PE * X_MESH / DATA_LEN,
  parameter int GROUP_BANKS  = DDR_DATA_LEN / DATA_LEN,
  parameter int GROUPS       = BUFFER_NUM / GROUP_BANKS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_LEN-1:0]     cmd_base_addr,
  input  logic [ADDR_LEN-1:0]     cmd_rows,
  input  logic [DDR_DATA_LEN-1:0] ddr_data,
  input  logic                    ddr_valid,
  output logic                    ddr_ready,
  output logic [DDR_DATA_LEN-1:0] data_wr,
  output logic [ADDR_LEN-1:0]     wr_addr,
  output logic [BUFFER_NUM-1:0]   wr_en,
  output logic                    busy,
  output logic                    done
);

  localparam int GRP_W = $clog2(GROUPS);
  localparam logic [GRP_W-1:0]      GRP_LAST = GRP_W'(GROUPS - 1);
  localparam logic [BUFFER_NUM-1:0] GRP_MASK = BUFFER_NUM'((1 << GROUP_BANKS) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state, state_nxt;
  logic [GRP_W-1:0]    grp;
  logic [ADDR_LEN-1:0] cur_addr;
  logic [ADDR_LEN-1:0] row_cnt;
  logic [ADDR_LEN-1:0] rows_q;

  logic cmd_fire;
  logic beat;
  logic last_beat;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat      = ddr_valid && ddr_ready;
  // rows_q is never 0 in LOAD, so rows_q-1 cannot underflow here.
  assign last_beat = (grp == GRP_LAST) && (row_cnt == rows_q - ADDR_LEN'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_fire) state_nxt = (cmd_rows == '0) ? DONE : LOAD;
      LOAD: if (beat && last_beat) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is held low while reset is asserted so every output reads 0.
  always_comb begin
    cmd_ready = 1'b0;
    ddr_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: cmd_ready = rst_n;
      LOAD: begin
        ddr_ready = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp      <= '0;
      cur_addr <= '0;
      row_cnt  <= '0;
      rows_q   <= '0;
      data_wr  <= '0;
      wr_addr  <= '0;
      wr_en    <= '0;
    end else begin
      wr_en <= '0;
      if (cmd_fire) begin
        cur_addr <= cmd_base_addr;
        rows_q   <= cmd_rows;
        grp      <= '0;
        row_cnt  <= '0;
      end
      if (beat) begin
        data_wr <= ddr_data;
        wr_addr <= cur_addr;
        wr_en   <= GRP_MASK << (int'(grp) * GROUP_BANKS);
        if (grp == GRP_LAST) begin
          grp      <= '0;
          cur_addr <= cur_addr + ADDR_LEN'(1);
          row_cnt  <= row_cnt + ADDR_LEN'(1);
        end else begin
          grp <= grp + GRP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_loader.sv
module tb_weight_buffer_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [15:0]  cmd_base_addr;
  logic [15:0]  cmd_rows;
  logic [255:0] ddr_data;
  logic         ddr_valid;
  logic         ddr_ready;
  logic [255:0] data_wr;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_en;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weight_buffer_loader dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_addr(cmd_base_addr), .cmd_rows(cmd_rows),
    .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready),
    .data_wr(data_wr), .wr_addr(wr_addr), .wr_en(wr_en),
    .busy(busy), .done(done)
  );

  function automatic logic [255:0] data_of(int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(k);
    return {8{w}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command until it is accepted (bounded), then withdraws it.
  task automatic send_cmd(input logic [15:0] base, input logic [15:0] rows);
    int t;
    cmd_valid     = 1'b1;
    cmd_base_addr = base;
    cmd_rows      = rows;
    t = 0;
    while (!cmd_ready && t < 50) begin
      tick();
      t++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Streams `total` beats (optionally every other cycle) and checks every
  // cycle's write port. Returns at the sample point where done is expected.
  task automatic stream(input logic [15:0] base, input int total, input bit gap);
    int  k;
    bit  fired;
    bit  finished;
    logic [15:0] exp_addr;
    k = 0;
    finished = 0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      ddr_valid = gap ? (cyc % 2 == 0) : 1'b1;
      ddr_data  = data_of(k);
      fired     = ddr_valid && ddr_ready;
      tick();
      if (fired) begin
        exp_addr = base + 16'(k / 8);
        chk("wr_en",   wr_en,   32'h0000_000F << (4 * (k % 8)));
        chk("wr_addr", wr_addr, exp_addr);
        chk("data_wr", data_wr, data_of(k));
        chk("done",    done,    (k == total - 1));
        k++;
        if (k == total) begin
          finished  = 1;
          ddr_valid = 1'b0;
        end
      end else begin
        chk("wr_en_gap", wr_en, 0);
        chk("done_gap",  done,  0);
      end
    end
    if (!finished) chk("stream_timeout", k, total);
  endtask

  initial begin
    rst_n         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_base_addr = '0;
    cmd_rows      = '0;
    ddr_data      = '0;
    ddr_valid     = 1'b0;

    // reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_en",     wr_en,     0);
    chk("rst_busy",      busy,      0);
    chk("rst_done",      done,      0);
    chk("rst_ddr_ready", ddr_ready, 0);
    chk("rst_wr_addr",   wr_addr,   0);
    #4 rst_n = 1'b1;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);
    tick();

    // one row, back-to-back beats
    send_cmd(16'h0010, 16'd1);
    chk("load_busy",      busy,      1);
    chk("load_ddr_ready", ddr_ready, 1);
    chk("load_cmd_ready", cmd_ready, 0);
    stream(16'h0010, 8, 0);
    chk("done_busy", busy, 1);
    tick();
    chk("post_busy",  busy,      0);
    chk("post_done",  done,      0);
    chk("post_ready", cmd_ready, 1);
    chk("post_wr_en", wr_en,     0);
    chk("hold_addr",  wr_addr,   16'h0010);
    chk("hold_data",  data_wr,   data_of(7));

    // three rows with ddr_valid gaps
    send_cmd(16'h0100, 16'd3);
    stream(16'h0100, 24, 1);
    tick();
    chk("r3_busy", busy, 0);
    chk("r3_done", done, 0);

    // zero rows: straight to DONE, no writes
    send_cmd(16'h0200, 16'd0);
    chk("z_cmd_ready", cmd_ready, 0);
    chk("z_done",      done,      1);
    chk("z_busy",      busy,      1);
    chk("z_wr_en",     wr_en,     0);
    chk("z_ddr_ready", ddr_ready, 0);
    tick();
    chk("z_done2",  done,      0);
    chk("z_ready2", cmd_ready, 1);
    chk("z_wr_en2", wr_en,     0);

    // address wrap 0xFFFF -> 0x0000
    send_cmd(16'hFFFF, 16'd2);
    stream(16'hFFFF, 16, 0);
    tick();
    chk("wrap_busy", busy, 0);

    // reset after the 5th beat of a one-row load
    send_cmd(16'h0030, 16'd1);
    ddr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ddr_data = data_of(k);
      tick();
    end
    ddr_valid = 1'b0;
    chk("pre_rst_wr_en", wr_en, 32'h000F_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_busy",  busy,  0);
    chk("arst_done",  done,  0);
    tick();
    chk("arst_done2", done, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("rel_done",  done,      0);
    chk("rel_ready", cmd_ready, 1);
    send_cmd(16'h0020, 16'd1);
    stream(16'h0020, 8, 0);
    tick();

    // command held during LOAD is taken only in the IDLE cycle after done
    cmd_valid     = 1'b1;
    cmd_base_addr = 16'h0040;
    cmd_rows      = 16'd1;
    tick();
    cmd_base_addr = 16'h0050;
    cmd_rows      = 16'd1;
    stream(16'h0040, 8, 0);
    chk("hold_done_ready", cmd_ready, 0);
    tick();
    chk("hold_idle_ready", cmd_ready, 1);
    chk("hold_idle_busy",  busy,      0);
    tick();
    cmd_valid = 1'b0;
    chk("hold_second_busy", busy, 1);
    stream(16'h0050, 8, 0);
    tick();
    chk("end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
